// File: rtl/lamp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lamp_pkg
//  Description : Shared definitions for the lamp fade sequencer: the 3-bit
//                phase encoding and the default fade-pattern levels.
//  Revision    : 1.0 - initial release
// ============================================================================
package lamp_pkg;

    // Phase encoding; IDLE..DN2 are numerically below UP3 so "flick accepted"
    // can be tested with a single magnitude compare.
    typedef logic [2:0] phase_t;

    localparam phase_t c_PH_IDLE = 3'd0;
    localparam phase_t c_PH_UP1  = 3'd1;
    localparam phase_t c_PH_DN1  = 3'd2;
    localparam phase_t c_PH_UP2  = 3'd3;
    localparam phase_t c_PH_DN2  = 3'd4;
    localparam phase_t c_PH_UP3  = 3'd5;
    localparam phase_t c_PH_DN3  = 3'd6;

    // Default fade-pattern levels
    localparam int c_DEF_P1 = 15;
    localparam int c_DEF_T1 = 4;
    localparam int c_DEF_P2 = 10;
    localparam int c_DEF_P3 = 5;

endpackage : lamp_pkg
`default_nettype wire

// File: rtl/lamp_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : lamp_pwm
//  Description : Free-running W-bit PWM generator. The output is a registered
//                compare of the wrap counter against the requested level, so
//                level 0 gives 0% duty and level 2^W-1 gives (2^W-1)/2^W.
//  Ports       : clk   - system clock
//                rst   - synchronous active-high reset
//                level - brightness level (0..2^W-1)
//                pwm   - lamp drive
//  Revision    : 1.0 - initial release
// ============================================================================
module lamp_pwm #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] level,
    output logic         pwm
);

    logic [W-1:0] r_cnt;
    logic         r_pwm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_pwm <= 1'b0;
        end else begin
            r_cnt <= r_cnt + W'(1);
            r_pwm <= (r_cnt < level);
        end
    end

    assign pwm = r_pwm;

endmodule : lamp_pwm
`default_nettype wire

// File: rtl/lamp_fade_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lamp_fade_sequencer
//  Description : Multi-phase lamp fade sequencer. A flick request starts the
//                pattern up-to-P1, down-to-T1, up-to-P2, down-to-0, up-to-P3,
//                down-to-0. A flick latched before a checkpoint (T1 in DN1,
//                T1 or 0 in DN2) repeats the previous climb, up to RETRIG_MAX
//                times per sequence. The level drives a PWM lamp output.
//  Ports       : clk       - system clock
//                rst       - synchronous active-high reset
//                step_en_i - level-step tick
//                flick_i   - single-cycle flick request
//                level_o   - current brightness level
//                phase_o   - current phase (0 IDLE .. 6 DN3)
//                busy_o    - sequence in progress
//                done_o    - one-cycle pulse on return to IDLE
//                retrig_o  - retriggers consumed in current sequence
//                pwm_o     - PWM lamp drive
//  Revision    : 1.0 - initial release
// ============================================================================
module lamp_fade_sequencer
    import lamp_pkg::*;
#(
    parameter int W          = 5,
    parameter int P1         = c_DEF_P1,
    parameter int T1         = c_DEF_T1,
    parameter int P2         = c_DEF_P2,
    parameter int P3         = c_DEF_P3,
    parameter int RETRIG_MAX = 3,
    parameter int RW         = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step_en_i,
    input  logic          flick_i,
    output logic [W-1:0]  level_o,
    output logic [2:0]    phase_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [RW-1:0] retrig_o,
    output logic          pwm_o
);

    localparam logic [W-1:0] c_P1   = W'(P1);
    localparam logic [W-1:0] c_T1   = W'(T1);
    localparam logic [W-1:0] c_P2   = W'(P2);
    localparam logic [W-1:0] c_P3   = W'(P3);
    localparam logic [W-1:0] c_ZERO = '0;
    localparam logic [W-1:0] c_ONE  = W'(1);

    phase_t        r_phase;
    logic [W-1:0]  r_level;
    logic          r_pend;
    logic [RW-1:0] r_retrig;
    logic          r_busy;
    logic          r_done;

    logic w_ok;
    logic w_flick_ok;
    logic w_to_up3;

    // Retrigger permission; with RETRIG_MAX == 0 the checkpoints never fire.
    generate
        if (RETRIG_MAX == 0) begin : g_no_retrig
            assign w_ok = 1'b0;
        end else begin : g_retrig
            localparam logic [RW-1:0] c_RMAX = RW'(RETRIG_MAX);
            assign w_ok = r_pend && (r_retrig < c_RMAX);
        end
    endgenerate

    // Flicks are only latched in IDLE..DN2.
    assign w_flick_ok = flick_i && (r_phase < c_PH_UP3);

    // Entering UP3 discards any pending flick, including one arriving on the
    // same cycle, so a late flick cannot restart the pattern after DN3.
    assign w_to_up3 = step_en_i && (r_phase == c_PH_DN2) &&
                      (r_level == c_ZERO) && !w_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase  <= c_PH_IDLE;
            r_level  <= '0;
            r_pend   <= 1'b0;
            r_retrig <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (step_en_i) begin
                case (r_phase)
                    c_PH_IDLE: begin
                        if (r_pend) begin
                            r_phase <= c_PH_UP1;
                            r_level <= c_ONE;
                            r_pend  <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end
                    c_PH_UP1: begin
                        if (r_level < c_P1) begin
                            r_level <= r_level + c_ONE;
                        end else begin
                            r_phase <= c_PH_DN1;
                            r_level <= r_level - c_ONE;
                        end
                    end
                    c_PH_DN1: begin
                        if (r_level == c_T1) begin
                            // Checkpoint: pend is either consumed or dropped.
                            r_pend  <= 1'b0;
                            r_level <= r_level + c_ONE;
                            if (w_ok) begin
                                r_phase  <= c_PH_UP1;
                                r_retrig <= r_retrig + RW'(1);
                            end else begin
                                r_phase <= c_PH_UP2;
                            end
                        end else begin
                            r_level <= r_level - c_ONE;
                        end
                    end
                    c_PH_UP2: begin
                        if (r_level == c_P2) begin
                            r_phase <= c_PH_DN2;
                            r_level <= r_level - c_ONE;
                        end else begin
                            r_level <= r_level + c_ONE;
                        end
                    end
                    c_PH_DN2: begin
                        if (((r_level == c_T1) || (r_level == c_ZERO)) && w_ok) begin
                            r_phase  <= c_PH_UP2;
                            r_level  <= r_level + c_ONE;
                            r_retrig <= r_retrig + RW'(1);
                            r_pend   <= 1'b0;
                        end else if (r_level == c_ZERO) begin
                            r_phase <= c_PH_UP3;
                            r_level <= c_ONE;
                            r_pend  <= 1'b0;
                        end else begin
                            r_level <= r_level - c_ONE;
                            if (r_level == c_T1) begin
                                r_pend <= 1'b0;
                            end
                        end
                    end
                    c_PH_UP3: begin
                        if (r_level == c_P3) begin
                            r_phase <= c_PH_DN3;
                            r_level <= r_level - c_ONE;
                        end else begin
                            r_level <= r_level + c_ONE;
                        end
                    end
                    c_PH_DN3: begin
                        if (r_level == c_ZERO) begin
                            r_phase  <= c_PH_IDLE;
                            r_retrig <= '0;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            r_level <= r_level - c_ONE;
                        end
                    end
                    default: begin
                        r_phase <= c_PH_IDLE;
                        r_level <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end

            // A new flick wins over consumption on the same cycle.
            if (w_flick_ok && !w_to_up3) begin
                r_pend <= 1'b1;
            end
        end
    end

    lamp_pwm #(
        .W (W)
    ) u_pwm (
        .clk   (clk),
        .rst   (rst),
        .level (r_level),
        .pwm   (pwm_o)
    );

    assign level_o  = r_level;
    assign phase_o  = r_phase;
    assign busy_o   = r_busy;
    assign done_o   = r_done;
    assign retrig_o = r_retrig;

endmodule : lamp_fade_sequencer
`default_nettype wire

// File: tb/tb_lamp_fade_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lamp_fade_sequencer
//  Description : Directed self-checking bench for lamp_fade_sequencer. One
//                instance uses the defaults, a second uses RETRIG_MAX = 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lamp_fade_sequencer;

    logic       r_clk = 1'b0;
    logic       r_rst = 1'b1;
    logic       r_step = 1'b0;
    logic       r_flick0 = 1'b0;
    logic       r_flick1 = 1'b0;

    logic [4:0] w_level0, w_level1;
    logic [2:0] w_phase0, w_phase1;
    logic       w_busy0, w_busy1;
    logic       w_done0, w_done1;
    logic [1:0] w_retrig0, w_retrig1;
    logic       w_pwm0, w_pwm1;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;

    always #5 r_clk = ~r_clk;

    lamp_fade_sequencer u_dut0 (
        .clk       (r_clk),
        .rst       (r_rst),
        .step_en_i (r_step),
        .flick_i   (r_flick0),
        .level_o   (w_level0),
        .phase_o   (w_phase0),
        .busy_o    (w_busy0),
        .done_o    (w_done0),
        .retrig_o  (w_retrig0),
        .pwm_o     (w_pwm0)
    );

    lamp_fade_sequencer #(.RETRIG_MAX(1)) u_dut1 (
        .clk       (r_clk),
        .rst       (r_rst),
        .step_en_i (r_step),
        .flick_i   (r_flick1),
        .level_o   (w_level1),
        .phase_o   (w_phase1),
        .busy_o    (w_busy1),
        .done_o    (w_done1),
        .retrig_o  (w_retrig1),
        .pwm_o     (w_pwm1)
    );

    always @(negedge r_clk) begin
        if (w_done0) done_cnt0++;
        if (w_done1) done_cnt1++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    function automatic logic [2:0] ph(input int sel);
        return (sel == 0) ? w_phase0 : w_phase1;
    endfunction

    function automatic logic [4:0] lv(input int sel);
        return (sel == 0) ? w_level0 : w_level1;
    endfunction

    task automatic pulse_flick(input int sel);
        if (sel == 0) r_flick0 = 1'b1; else r_flick1 = 1'b1;
        tick();
        r_flick0 = 1'b0;
        r_flick1 = 1'b0;
    endtask

    task automatic run_until(input int sel, input logic [2:0] p, input logic [4:0] l,
                             input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            if (ph(sel) == p && lv(sel) == l) found = 1'b1;
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    task automatic run_done(input int sel, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            if ((sel == 0) ? w_done0 : w_done1) found = 1'b1;
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    initial begin
        int q[$];
        int tgt[6] = '{15, 4, 10, 0, 5, 0};
        int cur;
        int prev;
        int hi;
        int d_snap;

        // Expected level after each step of the single-flick pattern
        cur = 0;
        q.push_back(0);
        for (int k = 0; k < 6; k++) begin
            while (cur != tgt[k]) begin
                cur += (tgt[k] > cur) ? 1 : -1;
                q.push_back(cur);
            end
        end

        // ---------------- reset state
        tick(); tick();
        chk("rst_level", w_level0, 0);
        chk("rst_phase", w_phase0, 0);
        chk("rst_busy", w_busy0, 0);
        chk("rst_done", w_done0, 0);
        chk("rst_retrig", w_retrig0, 0);
        chk("rst_pwm", w_pwm0, 0);
        r_rst = 1'b0;

        // ---------------- 1: single flick, step every cycle
        r_step = 1'b1;
        pulse_flick(0);
        chk("t1_pend_no_step_yet", w_level0, 0);
        for (int s = 1; s <= 53; s++) begin
            tick();
            if (s <= 52) chk($sformatf("t1_lvl_s%0d", s), w_level0, q[s]);
            if (s == 1)  chk("t1_busy", w_busy0, 1);
            if (s == 15) chk("t1_ph_up1", w_phase0, 1);
            if (s == 16) chk("t1_ph_dn1", w_phase0, 2);
            if (s == 27) chk("t1_ph_up2", w_phase0, 3);
            if (s == 43) chk("t1_ph_up3", w_phase0, 5);
            if (s == 48) chk("t1_ph_dn3", w_phase0, 6);
            if (s == 30) chk("t1_retrig", w_retrig0, 0);
            if (s == 52) chk("t1_no_early_done", w_done0, 0);
            if (s == 53) begin
                chk("t1_done", w_done0, 1);
                chk("t1_idle", w_phase0, 0);
                chk("t1_busy_end", w_busy0, 0);
            end
        end
        tick();
        chk("t1_done_1cyc", w_done0, 0);

        // ---------------- 2: flick at level 8 in DN1
        pulse_flick(0);
        run_until(0, 3'd2, 5'd8, "t2_reach_dn1_8");
        pulse_flick(0);
        chk("t2_lvl7", w_level0, 7);
        run_until(0, 3'd1, 5'd5, "t2_retrig_up1");
        chk("t2_retrig1", w_retrig0, 1);
        run_until(0, 3'd1, 5'd15, "t2_second_peak");
        tick();
        chk("t2_dn1_again_ph", w_phase0, 2);
        chk("t2_dn1_again_lv", w_level0, 14);
        run_done(0, "t2_done");
        tick();
        chk("t2_retrig_clr", w_retrig0, 0);

        // ---------------- 3: DN2 checkpoints with RETRIG_MAX = 1
        pulse_flick(1);
        run_until(1, 3'd4, 5'd5, "t3_dn2_5a");
        pulse_flick(1);
        tick();
        chk("t3_up2_ph", w_phase1, 3);
        chk("t3_up2_lv", w_level1, 5);
        chk("t3_retrig1", w_retrig1, 1);
        run_until(1, 3'd4, 5'd5, "t3_dn2_5b");
        pulse_flick(1);
        tick();
        chk("t3_ignored_ph", w_phase1, 4);
        chk("t3_ignored_lv", w_level1, 3);
        run_until(1, 3'd4, 5'd1, "t3_dn2_1");
        pulse_flick(1);
        tick();
        chk("t3_up3_ph", w_phase1, 5);
        chk("t3_up3_lv", w_level1, 1);
        run_done(1, "t3_done");
        for (int i = 0; i < 5; i++) tick();
        chk("t3_stay_idle", w_phase1, 0);
        chk("t3_retrig_clr", w_retrig1, 0);

        // ---------------- 4: step every 4th cycle
        r_step = 1'b0;
        pulse_flick(0);
        for (int c = 1; c <= 212; c++) begin
            prev = w_level0;
            r_step = (c % 4 == 0);
            tick();
            if (c < 212) chk($sformatf("t4_move_c%0d", c), 32'(w_level0 != prev[4:0]), 32'(c % 4 == 0));
            if (c == 211) chk("t4_no_early_done", w_done0, 0);
            if (c == 212) chk("t4_done_212", w_done0, 1);
        end
        r_step = 1'b1;

        // ---------------- 5: reset mid-sequence
        pulse_flick(0);
        run_until(0, 3'd1, 5'd12, "t5_reach_12");
        d_snap = done_cnt0;
        r_rst = 1'b1;
        tick();
        r_rst = 1'b0;
        chk("t5_level", w_level0, 0);
        chk("t5_phase", w_phase0, 0);
        chk("t5_busy", w_busy0, 0);
        chk("t5_pwm", w_pwm0, 0);
        chk("t5_done", w_done0, 0);
        tick(); tick();
        chk("t5_no_done", done_cnt0, d_snap);
        chk("t5_still_idle", w_phase0, 0);
        pulse_flick(0);
        tick();
        chk("t5_restart_lv", w_level0, 1);
        chk("t5_restart_ph", w_phase0, 1);
        run_done(0, "t5_done_after");

        // ---------------- 6: flick in UP3 ignored, PWM duty
        pulse_flick(0);
        run_until(0, 3'd5, 5'd3, "t6_up3_3");
        pulse_flick(0);
        chk("t6_up3_4", w_level0, 4);
        run_done(0, "t6_done");
        for (int i = 0; i < 5; i++) tick();
        chk("t6_stay_idle", w_phase0, 0);
        chk("t6_level0", w_level0, 0);

        hi = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (w_pwm0) hi++;
        end
        chk("t6_pwm_lvl0", hi, 0);

        pulse_flick(0);
        run_until(0, 3'd1, 5'd8, "t6_lvl8");
        r_step = 1'b0;
        tick(); tick();
        hi = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (w_pwm0) hi++;
        end
        chk("t6_pwm_lvl8", hi, 16);
        chk("t6_lvl_held", w_level0, 8);
        r_rst = 1'b1;
        tick();
        r_rst = 1'b0;
        tick();

        chk("done_total0", done_cnt0, 5);
        chk("done_total1", done_cnt1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_lamp_fade_sequencer
`default_nettype wire

// File: doc/lamp_fade_sequencer.md
Name: lamp_fade_sequencer

Overview:
Clocked, parametrised lamp brightness sequencer: a flick request starts a multi-phase fade pattern (up to P1, down to T1, up to P2, down to 0, up to P3, down to 0), with flick-driven retrigger at defined checkpoints.
Generalises the fixed 16-level combinational next-state logic.
Adds a registered state/level, tick-gated stepping, a latched flick request, a bounded retrigger count, a done pulse and a PWM lamp drive.
Sits between the button debouncer (flick source) and the lamp driver pin.

Parameters:
W, 5, level/PWM counter width; level range 0..2^W-1
P1, 15, first peak level
T1, 4, trough/checkpoint level; constraint 0 < T1 < P2 <= P1 < 2^W
P2, 10, second peak level
P3, 5, final peak level; 0 < P3 <= P2
RETRIG_MAX, 3, max checkpoint retriggers per sequence; 0 disables retrigger
RW, 2, retrigger counter width; RETRIG_MAX < 2^RW

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
step_en_i  in  1  level-step tick; level/phase advance only on cycles where high
flick_i  in  1  flick request pulse (single-cycle, pre-debounced)
level_o  out  W  current brightness level
phase_o  out  3  0 IDLE, 1 UP1, 2 DN1, 3 UP2, 4 DN2, 5 UP3, 6 DN3
busy_o  out  1  phase_o != IDLE
done_o  out  1  one-cycle pulse on return to IDLE
retrig_o  out  RW  retriggers consumed in current sequence
pwm_o  out  1  lamp drive, high while pwm_cnt < level_o

Behaviour:
- Reset (synchronous, active-high, clk): phase IDLE, level 0, pend 0, retrig 0, pwm_cnt 0. All outputs 0. Reset mid-sequence aborts immediately with no done pulse.
- pend: set by flick_i in IDLE, UP1, DN1, UP2, DN2. Ignored in UP3/DN3. Cleared on consumption and on entry to UP3. Flick on the consuming cycle re-sets pend (set wins).
- ok = pend && (retrig < RETRIG_MAX). At a checkpoint where pend && !ok, pend is cleared.
- All transitions below occur only on step_en_i=1 cycles; otherwise the state holds. Level changes by exactly ±1 per step. No wrap or saturation is reachable under the parameter constraints.
- IDLE: if pend, go to UP1 with level 1 and consume pend (not counted as a retrigger); else level stays 0.
- UP1: if level < P1, level+1; else go to DN1 with level-1.
- DN1: if level == T1: if ok, go to UP1 (retrig+1); else go to UP2. Both take level+1. Otherwise level-1.
- UP2: if level == P2, go to DN2 with level-1; else level+1.
- DN2: if (level == T1 or level == 0) and ok, go to UP2 with level+1 and retrig+1. Else if level == 0, go to UP3 with level+1. Else level-1.
- UP3: if level == P3, go to DN3 with level-1; else level+1.
- DN3: if level == 0, go to IDLE; level stays 0, retrig cleared, done_o=1 for that cycle. Else level-1.
- Output timing: all outputs are registered; level_o/phase_o update the cycle after the step.
- PWM: pwm_cnt is a free-running W-bit wrap counter, independent of step_en_i. pwm_o is registered compare of pwm_cnt < level_o: 0% duty at level 0, max duty (2^W-1)/2^W.

Decomposition:
- Shared package lamp_pkg: phase enum (IDLE..DN3, 3 bits) and default level constants P1/T1/P2/P3.
- Sub-module lamp_pwm (W parameter; ports clk, rst, level, pwm): counter plus compare.
- Sequencer FSM and pend/retrig logic stay in the top module.

Test Plan:
1. Single flick in IDLE, step_en_i=1 constant, defaults -> level 0,1..15,14..4,5..10,9..0,1..5,4..0. done_o on step 53. retrig_o stays 0.
2. Flick when level=8 in DN1 -> at level 4 phase returns to UP1, level 5, retrig_o=1. Second peak reaches 15 before DN1 resumes.
3. Flick at every DN2 checkpoint with RETRIG_MAX=1 -> first flick at level 4 returns to UP2 (retrig_o=1). Later flicks are ignored: at level 0 the block goes to UP3, pend clears, sequence completes.
4. step_en_i high 1 cycle in 4 -> level_o changes only in cycles after step ticks. Single-flick pattern takes 212 cycles to done_o.
5. rst asserted at level 12 in UP1 -> next cycle level_o=0, phase IDLE, busy_o=0, pwm_o=0, no done_o. A flick after reset restarts from level 1.
6. Flick during UP3 at level 3 -> ignored, DN3 completes to IDLE. Separately, level 8 with W=5 -> pwm_o high 8 of every 32 cycles.
